// File: rtl/bist_adder_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bist_adder_controller
// Brief    : BIST controller around a WIDTH-bit ripple-carry adder (the CUT).
//            It applies counter or LFSR patterns and checks each result
//            against a golden adder. Results are compressed into a MISR.
//            A stuck-at injection hook can force one CUT output bit.
// Revision : 1.0 - initial release
// ============================================================================
module bist_adder_controller #(
    parameter int               WIDTH        = 4,
    parameter int               NUM_PATTERNS = 2**(2*WIDTH+1),
    parameter logic [2*WIDTH:0] LFSR_TAPS    = 9'h110,
    parameter logic [WIDTH:0]   MISR_TAPS    = 5'h13
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         testmode,
    input  logic                         start,
    input  logic                         pattern_mode,
    input  logic [WIDTH-1:0]             a_in,
    input  logic [WIDTH-1:0]             b_in,
    input  logic                         cin_in,
    input  logic                         inject_en,
    input  logic [$clog2(WIDTH+1)-1:0]   inject_bit,
    input  logic                         inject_val,
    output logic [WIDTH-1:0]             sum_out,
    output logic                         cout_out,
    output logic                         busy,
    output logic                         done,
    output logic                         fault_detected,
    output logic [15:0]                  fail_count,
    output logic [2*WIDTH:0]             first_fail_pattern,
    output logic [WIDTH:0]               signature
);

    localparam int c_PW    = 2*WIDTH+1;
    localparam int c_SW    = WIDTH+1;
    localparam int c_CNT_W = $clog2(NUM_PATTERNS+1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_PATTERNS-1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_INIT = 2'd1;
    localparam logic [1:0] c_S_RUN  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PW-1:0]    r_pattern;
    logic               r_mode;
    logic               r_fault;
    logic [15:0]        r_fail_count;
    logic [c_PW-1:0]    r_first_fail;
    logic [c_SW-1:0]    r_sig;

    logic               w_test_active;
    logic [c_PW-1:0]    w_cut_in;
    logic [WIDTH-1:0]   w_cut_a;
    logic [WIDTH-1:0]   w_cut_b;
    logic               w_cut_cin;
    logic [WIDTH-1:0]   w_cut_sum;
    logic [WIDTH:0]     w_carry;
    logic [c_SW-1:0]    w_cut_raw;
    logic [c_SW-1:0]    w_cut_out;
    logic [c_SW-1:0]    w_gold;
    logic               w_mismatch;
    logic               w_lfsr_fb;
    logic [c_PW-1:0]    w_pattern_next;

    assign w_test_active = (r_state == c_S_INIT) || (r_state == c_S_RUN);
    assign w_cut_in      = w_test_active ? r_pattern : {a_in, b_in, cin_in};
    assign w_cut_a       = w_cut_in[c_PW-1:WIDTH+1];
    assign w_cut_b       = w_cut_in[WIDTH:1];
    assign w_cut_cin     = w_cut_in[0];

    // Circuit under test: explicit ripple-carry chain
    assign w_carry[0] = w_cut_cin;
    for (genvar i = 0; i < WIDTH; i++) begin : g_rca
        assign w_cut_sum[i]   = w_cut_a[i] ^ w_cut_b[i] ^ w_carry[i];
        assign w_carry[i+1]   = (w_cut_a[i] & w_cut_b[i]) |
                                (w_carry[i] & (w_cut_a[i] ^ w_cut_b[i]));
    end
    assign w_cut_raw = {w_carry[WIDTH], w_cut_sum};

    always_comb begin
        w_cut_out = w_cut_raw;
        if (inject_en) begin
            for (int i = 0; i < c_SW; i++) begin
                if (int'(inject_bit) == i) begin
                    w_cut_out[i] = inject_val;
                end
            end
        end
    end

    // Golden reference sees the same operands but never the injected fault
    assign w_gold     = {1'b0, w_cut_a} + {1'b0, w_cut_b} + {{WIDTH{1'b0}}, w_cut_cin};
    assign w_mismatch = (w_cut_out != w_gold);

    assign w_lfsr_fb      = ^(r_pattern & LFSR_TAPS);
    assign w_pattern_next = r_mode ? {r_pattern[c_PW-2:0], w_lfsr_fb}
                                   : r_pattern + c_PW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: if (testmode && start) w_state_next = c_S_INIT;
            c_S_INIT: w_state_next = testmode ? c_S_RUN : c_S_IDLE;
            c_S_RUN: begin
                if (!testmode) begin
                    w_state_next = c_S_IDLE;
                end else if (r_count == c_LAST) begin
                    w_state_next = c_S_DONE;
                end
            end
            c_S_DONE: begin
                if (!testmode) begin
                    w_state_next = c_S_IDLE;
                end else if (start) begin
                    w_state_next = c_S_INIT;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // An abort (testmode low) freezes all results at their partial values
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_pattern    <= '0;
            r_mode       <= 1'b0;
            r_fault      <= 1'b0;
            r_fail_count <= '0;
            r_first_fail <= '0;
            r_sig        <= '0;
        end else if (testmode) begin
            case (r_state)
                c_S_INIT: begin
                    r_count      <= '0;
                    r_mode       <= pattern_mode;
                    r_pattern    <= pattern_mode ? '1 : '0;
                    r_fault      <= 1'b0;
                    r_fail_count <= '0;
                    r_first_fail <= '0;
                    r_sig        <= '0;
                end
                c_S_RUN: begin
                    r_count   <= r_count + c_CNT_W'(1);
                    r_pattern <= w_pattern_next;
                    if (w_mismatch) begin
                        r_fault <= 1'b1;
                        if (r_fail_count == 16'd0) begin
                            r_first_fail <= r_pattern;
                        end
                        if (r_fail_count != 16'hFFFF) begin
                            r_fail_count <= r_fail_count + 16'd1;
                        end
                    end
                    r_sig <= ({r_sig[WIDTH-1:0], 1'b0} ^ (r_sig[WIDTH] ? MISR_TAPS : '0))
                             ^ w_cut_out;
                end
                default: ;
            endcase
        end
    end

    assign sum_out            = w_cut_out[WIDTH-1:0];
    assign cout_out           = w_cut_out[WIDTH];
    assign busy               = w_test_active;
    assign done               = (r_state == c_S_DONE);
    assign fault_detected     = r_fault;
    assign fail_count         = r_fail_count;
    assign first_fail_pattern = r_first_fail;
    assign signature          = r_sig;

endmodule
`default_nettype wire

// File: tb/tb_bist_adder_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bist_adder_controller
// Brief    : Scoreboard bench for bist_adder_controller (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bist_adder_controller;

    localparam int W  = 4;
    localparam int NP = 512;

    typedef struct packed {
        logic        fault;
        logic [15:0] fails;
        logic [8:0]  first;
        logic [4:0]  sig;
    } res_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        testmode = 1'b0;
    logic        start = 1'b0;
    logic        pattern_mode = 1'b0;
    logic [3:0]  a_in = '0;
    logic [3:0]  b_in = '0;
    logic        cin_in = 1'b0;
    logic        inject_en = 1'b0;
    logic [2:0]  inject_bit = '0;
    logic        inject_val = 1'b0;
    logic [3:0]  sum_out;
    logic        cout_out;
    logic        busy;
    logic        done;
    logic        fault_detected;
    logic [15:0] fail_count;
    logic [8:0]  first_fail_pattern;
    logic [4:0]  signature;

    bist_adder_controller #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .testmode(testmode), .start(start),
        .pattern_mode(pattern_mode), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .inject_en(inject_en), .inject_bit(inject_bit), .inject_val(inject_val),
        .sum_out(sum_out), .cout_out(cout_out), .busy(busy), .done(done),
        .fault_detected(fault_detected), .fail_count(fail_count),
        .first_fail_pattern(first_fail_pattern), .signature(signature)
    );

    always #5 clock = ~clock;

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t q[$];
    res_t mon_e;
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk the pattern sequence and apply the run rules directly
    function automatic res_t model(input bit lfsr, input bit ie, input int ib, input bit iv);
        res_t       r;
        logic [8:0] p;
        r = '0;
        p = lfsr ? 9'h1FF : 9'h000;
        for (int i = 0; i < NP; i++) begin
            int         s;
            logic [4:0] gv;
            logic [4:0] cv;
            s  = int'(p[8:5]) + int'(p[4:1]) + int'(p[0]);
            gv = 5'(s);
            cv = gv;
            if (ie) cv[ib] = iv;
            if (cv != gv) begin
                r.fault = 1'b1;
                if (r.fails == 16'd0) r.first = p;
                if (r.fails != 16'hFFFF) r.fails = r.fails + 16'd1;
            end
            r.sig = {r.sig[3:0], 1'b0} ^ (r.sig[4] ? 5'h13 : 5'h00) ^ cv;
            if (lfsr) p = {p[7:0], p[8] ^ p[4]};
            else      p = p + 9'd1;
        end
        return r;
    endfunction

    // Monitor: every rising done retires one expected run result
    always @(negedge clock) begin
        if (done && !prev_done) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending run");
            end else begin
                mon_e = q.pop_front();
                check("fault_detected", 32'(fault_detected), 32'(mon_e.fault));
                check("fail_count", 32'(fail_count), 32'(mon_e.fails));
                check("first_fail_pattern", 32'(first_fail_pattern), 32'(mon_e.first));
                check("signature", 32'(signature), 32'(mon_e.sig));
            end
        end
        prev_done = done;
    end

    task automatic do_run(input bit lfsr, input bit ie, input int ib, input bit iv);
        int         n;
        logic [4:0] first_exp;
        pattern_mode = lfsr;
        inject_en    = ie;
        inject_bit   = 3'(ib);
        inject_val   = iv;
        q.push_back(model(lfsr, ie, ib, iv));
        first_exp = lfsr ? 5'h1F : 5'h00;
        if (ie) first_exp[ib] = iv;
        testmode = 1'b1;
        start    = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 1000) begin
            if (busy) begin
                n++;
                if (n == 2) check("first_cut_output", 32'({cout_out, sum_out}), 32'(first_exp));
            end
            @(posedge clock); #1;
        end
        check("busy_cycles", n, 513);
        check("done_reached", 32'(done), 32'd1);
        @(negedge clock); #1;
    endtask

    initial begin
        logic [4:0] exp5;
        int         s;

        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_fault", 32'(fault_detected), 0);
        check("rst_fail_count", 32'(fail_count), 0);
        check("rst_first_fail", 32'(first_fail_pattern), 0);
        check("rst_signature", 32'(signature), 0);
        check("rst_cut", 32'({cout_out, sum_out}), 0);
        @(negedge clock);
        reset = 1'b1;

        a_in = 4'd5; b_in = 4'd9; cin_in = 1'b1; #1;
        check("normal_5_9_1", 32'({cout_out, sum_out}), 32'h0F);
        a_in = 4'd15; b_in = 4'd1; cin_in = 1'b0; #1;
        check("normal_15_1_0", 32'({cout_out, sum_out}), 32'h10);

        // Random normal-mode traffic, sometimes with injection and stray starts
        for (int k = 0; k < 10; k++) begin
            a_in       = 4'($urandom_range(0, 15));
            b_in       = 4'($urandom_range(0, 15));
            cin_in     = 1'($urandom_range(0, 1));
            inject_en  = 1'($urandom_range(0, 1));
            inject_bit = 3'($urandom_range(0, 4));
            inject_val = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            s    = int'(a_in) + int'(b_in) + int'(cin_in);
            exp5 = 5'(s);
            if (inject_en) exp5[inject_bit] = inject_val;
            @(posedge clock); #1;
            check("normal_random", 32'({cout_out, sum_out}), 32'(exp5));
            check("normal_busy", 32'(busy), 0);
        end
        start = 1'b0;
        inject_en = 1'b0;

        do_run(1'b0, 1'b0, 0, 1'b0);
        do_run(1'b0, 1'b1, 0, 1'b0);
        do_run(1'b0, 1'b1, 4, 1'b1);
        do_run(1'b1, 1'b0, 0, 1'b0);
        do_run(1'b1, 1'b0, 0, 1'b0);

        // Abort partway through RUN
        inject_en = 1'b0; pattern_mode = 1'b0;
        testmode = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (101) begin @(posedge clock); #1; end
        check("pre_abort_busy", 32'(busy), 1);
        testmode = 1'b0;
        @(posedge clock); #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        do_run(1'b0, 1'b0, 0, 1'b0);

        for (int k = 0; k < 3; k++) begin
            do_run(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a faulty LFSR run
        pattern_mode = 1'b1; inject_en = 1'b1; inject_bit = 3'd2; inject_val = 1'b1;
        testmode = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (50) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_fault", 32'(fault_detected), 0);
        check("arst_fail_count", 32'(fail_count), 0);
        check("arst_first_fail", 32'(first_fail_pattern), 0);
        check("arst_signature", 32'(signature), 0);
        @(negedge clock);
        testmode = 1'b0; inject_en = 1'b0;
        reset = 1'b1;
        @(negedge clock);

        check("scoreboard_pending", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
